// File: rtl/key_debounce_repeat_if.sv
// key_debounce_repeat_if
// Bundles the raw push-button inputs with the cleaned key events.
//   KEY        raw buttons, active-low, asynchronous to CLK
//   KEY_STATE  debounced level, 1 = held
//   PRESS      one-cycle pulse when a press is accepted
//   RELEASE    one-cycle pulse when a release is accepted
//   STEP       one-cycle pulse on press and on each auto-repeat
// The master modport is the debouncer, which drives the events.
// The slave modport is the board/consumer side, which drives KEY.
interface key_debounce_repeat_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] KEY_STATE;
    logic [N_KEYS-1:0] PRESS;
    logic [N_KEYS-1:0] RELEASE;
    logic [N_KEYS-1:0] STEP;

    modport master (
        input  KEY,
        output KEY_STATE,
        output PRESS,
        output RELEASE,
        output STEP
    );

    modport slave (
        output KEY,
        input  KEY_STATE,
        input  PRESS,
        input  RELEASE,
        input  STEP
    );
endinterface

// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat
// Synchronises and debounces active-low push-buttons. Each key is turned into
// clean one-cycle PRESS / RELEASE / STEP events. STEP fires on press and then
// auto-repeats while the key stays held. Every key channel is independent.
// Ports:
//   CLK   system clock
//   RES   asynchronous active-low reset; deassertion is taken synchronously
//   kif   key_debounce_repeat_if.master (KEY in; KEY_STATE/PRESS/RELEASE/STEP out)
module key_debounce_repeat #(
    parameter int                N_KEYS       = 4,
    parameter int                CNT_W        = 26,
    parameter int                DEB_CYCLES   = 1000000,
    parameter int                DELAY_CYCLES = 25000000,
    parameter int                RATE_CYCLES  = 5000000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK  = {N_KEYS{1'b1}}
) (
    input  logic                         CLK,
    input  logic                         RES,
    key_debounce_repeat_if.master        kif
);

    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    // Cycle counts of 0 cannot be expressed by the equality compare, and
    // counts beyond the timer range would never match.
    if (DEB_CYCLES < 1 || longint'(DEB_CYCLES) > MAX_CNT ||
        DELAY_CYCLES < 1 || longint'(DELAY_CYCLES) > MAX_CNT ||
        RATE_CYCLES < 1 || longint'(RATE_CYCLES) > MAX_CNT) begin : g_bad_params
        $error("key_debounce_repeat: cycle parameter is 0 or exceeds the CNT_W timer range");
    end

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] lvl;
    logic [N_KEYS-1:0] state_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] step_q;
    logic [CNT_W-1:0]  deb_cnt [N_KEYS];
    logic [CNT_W-1:0]  rep_cnt [N_KEYS];
    logic [1:0]        fsm     [N_KEYS];

    logic [N_KEYS-1:0] mismatch;
    logic [N_KEYS-1:0] accept;
    logic [N_KEYS-1:0] rep_hit;

    // accept marks the edge on which a level change becomes KEY_STATE.
    // rep_hit marks the edge on which the repeat timer expires; the target
    // depends on whether we are waiting for the first repeat or a later one.
    always_comb begin
        mismatch = '0;
        accept   = '0;
        rep_hit  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            mismatch[i] = lvl[i] ^ state_q[i];
            accept[i]   = mismatch[i] && (deb_cnt[i] == DEB_LAST);
            rep_hit[i]  = (rep_cnt[i] == ((fsm[i] == ST_DELAY) ? DELAY_LAST : RATE_LAST));
        end
    end

    // The synchroniser resets to 1 (released) so a key held through reset is
    // seen as a fresh press. lvl is a registered, active-high copy of the
    // synchronised key, and it is what the debouncer compares against
    // KEY_STATE. Release acceptance is checked before repeat expiry, so a
    // release landing on a repeat edge suppresses that STEP.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            sync1     <= '1;
            sync2     <= '1;
            lvl       <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            step_q    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt[i] <= '0;
                rep_cnt[i] <= '0;
                fsm[i]     <= ST_IDLE;
            end
        end else begin
            sync1     <= kif.KEY;
            sync2     <= sync1;
            lvl       <= ~sync2;
            press_q   <= '0;
            release_q <= '0;
            step_q    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                if (!mismatch[i]) begin
                    deb_cnt[i] <= '0;
                end else if (accept[i]) begin
                    deb_cnt[i] <= '0;
                    state_q[i] <= lvl[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end

                case (fsm[i])
                    ST_IDLE: begin
                        if (accept[i] && lvl[i]) begin
                            press_q[i] <= 1'b1;
                            step_q[i]  <= 1'b1;
                            rep_cnt[i] <= '0;
                            fsm[i]     <= REPEAT_MASK[i] ? ST_DELAY : ST_HOLD;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (accept[i] && !lvl[i]) begin
                            release_q[i] <= 1'b1;
                            rep_cnt[i]   <= '0;
                            fsm[i]       <= ST_IDLE;
                        end else if (rep_hit[i]) begin
                            step_q[i]  <= 1'b1;
                            rep_cnt[i] <= '0;
                            fsm[i]     <= ST_REPEAT;
                        end else begin
                            rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (accept[i] && !lvl[i]) begin
                            release_q[i] <= 1'b1;
                            rep_cnt[i]   <= '0;
                            fsm[i]       <= ST_IDLE;
                        end
                    end
                    default: begin
                        rep_cnt[i] <= '0;
                        fsm[i]     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign kif.KEY_STATE = state_q;
    assign kif.PRESS     = press_q;
    assign kif.RELEASE   = release_q;
    assign kif.STEP      = step_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb_key_debounce_repeat
// Directed bench for key_debounce_repeat with short timer parameters.
// Simple press/bounce behaviour is checked from a vector table. Repeat,
// masking, concurrency, collision and reset behaviour are checked by
// per-cycle expectations that are derived from key press/release times.
module tb_key_debounce_repeat;

    localparam int         N_KEYS = 4;
    localparam int         CNT_W  = 8;
    localparam int         DEB    = 4;
    localparam int         DLY    = 20;
    localparam int         RATE   = 8;
    localparam logic [3:0] MASK   = 4'b0111;

    typedef int arr4_t [4];

    typedef struct {
        logic [3:0] key;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] sp;
    } vec_t;

    logic CLK = 1'b0;
    logic RES;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    vec_t vecs[$];

    key_debounce_repeat_if #(.N_KEYS(N_KEYS)) kif ();

    key_debounce_repeat #(
        .N_KEYS      (N_KEYS),
        .CNT_W       (CNT_W),
        .DEB_CYCLES  (DEB),
        .DELAY_CYCLES(DLY),
        .RATE_CYCLES (RATE),
        .REPEAT_MASK (MASK)
    ) dut (
        .CLK(CLK),
        .RES(RES),
        .kif(kif)
    );

    always #5 CLK = ~CLK;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] key);
        kif.KEY = key;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] st, input logic [3:0] pr,
                               input logic [3:0] rl, input logic [3:0] sp);
        n_compared++;
        if (kif.KEY_STATE !== st || kif.PRESS !== pr || kif.RELEASE !== rl || kif.STEP !== sp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got state=%b press=%b release=%b step=%b, want state=%b press=%b release=%b step=%b",
                     name, kif.KEY_STATE, kif.PRESS, kif.RELEASE, kif.STEP, st, pr, rl, sp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] key, input logic [3:0] st, input logic [3:0] pr,
                                input logic [3:0] rl, input logic [3:0] sp);
        vec_t v;
        v.key = key;
        v.st  = st;
        v.pr  = pr;
        v.rl  = rl;
        v.sp  = sp;
        return v;
    endfunction

    // Key k goes low before cycle press_at[k] and high again before cycle
    // rel_at[k] (-1 = never). An accepted change appears DEB+2 cycles after
    // the sampling cycle; repeats follow at DLY, then every RATE cycles.
    task automatic runModel(input string name, input arr4_t press_at, input arr4_t rel_at,
                            input int ncycles);
        logic [3:0] mask_v;
        mask_v = MASK;
        for (int c = 1; c <= ncycles; c++) begin
            logic [3:0] key, st, pr, rl, sp;
            key = 4'hF;
            st  = '0;
            pr  = '0;
            rl  = '0;
            sp  = '0;
            for (int k = 0; k < 4; k++) begin
                int  a, r;
                bit  held;
                if (press_at[k] >= 0) begin
                    if (c >= press_at[k] && (rel_at[k] < 0 || c < rel_at[k]))
                        key[k] = 1'b0;
                    a    = press_at[k] + DEB + 2;
                    r    = (rel_at[k] >= 0) ? rel_at[k] + DEB + 2 : -1;
                    held = (c >= a) && (r < 0 || c < r);
                    st[k] = held;
                    pr[k] = (c == a);
                    rl[k] = (r >= 0) && (c == r);
                    sp[k] = (c == a) ||
                            (held && mask_v[k] && (c - a) >= DLY && ((c - a - DLY) % RATE) == 0);
                end
            end
            applyStimulus(key);
            tick();
            checkOutput($sformatf("%s c%0d", name, c), st, pr, rl, sp);
        end
    endtask

    initial begin
        // Reset state
        RES = 1'b0;
        applyStimulus(4'hF);
        repeat (3) tick();
        checkOutput("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        RES = 1'b1;

        // Clean press on key 0, held 10 cycles, then released
        for (int i = 0; i < 6; i++) vecs.push_back(mk(4'b1110, 4'h0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'b1110, 4'h1, 4'h1, 4'h0, 4'h1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1110, 4'h1, 4'h0, 4'h0, 4'h0));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(4'b1111, 4'h1, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'b1111, 4'h0, 4'h0, 4'h1, 4'h0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0));
        // Bounce on key 1: low 3, high 1, low 3, then high
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1101, 4'h0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1101, 4'h0, 4'h0, 4'h0, 4'h0));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].key);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].pr, vecs[i].rl, vecs[i].sp);
        end

        // Auto-repeat on key 2: steps at +0,+20,+28,+36,+44,+52, release at +53
        runModel("repeat", '{-1, -1, 1, -1}, '{-1, -1, 54, -1}, 68);

        // Key 3 has repeat masked off: a single step per press
        runModel("masked", '{-1, -1, -1, 1}, '{-1, -1, -1, 61}, 72);

        // Keys 0 and 3 together; key 0 release accepted on its +20 repeat edge
        runModel("collide", '{1, -1, -1, 1}, '{21, -1, -1, 30}, 45);

        // Reset while key 2 is in REPEAT, key held through reset
        runModel("prereset", '{-1, -1, 1, -1}, '{-1, -1, -1, -1}, 40);
        RES = 1'b0;
        #1;
        checkOutput("reset async", 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("reset hold%0d", i), 4'h0, 4'h0, 4'h0, 4'h0);
        end
        RES = 1'b1;
        runModel("postreset", '{-1, -1, 1, -1}, '{-1, -1, -1, -1}, 36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
